// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolution-side partner of the gshare predictor.
// Keeps an in-order queue of fetch-time predictions, checks each one
// against the EXE outcome and drives predictor training plus the
// redirect/flush on a mispredict.
// Optional build macro: BRU_PERF_CNT_EN adds perf_branches/perf_mispredicts.
//
// Handshake: IF pushes a prediction when fetch_valid=1 and queue_full=0
// (a push while full is dropped). EXE resolves the oldest entry with a
// single-cycle ex_valid pulse; there is no back-pressure toward EXE.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_pred_taken,
  input  logic [31:0] fetch_pred_target,
  input  logic        ex_valid,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        queue_full,
  output logic        update,
  output logic        actual_taken,
  output logic        mispredict,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
`ifdef BRU_PERF_CNT_EN
  output logic        order_err,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`else
  output logic        order_err
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  logic [FCW-1:0]  flush_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     pc_q   [DEPTH];
  logic            pt_q   [DEPTH];
  logic [31:0]     tgt_q  [DEPTH];

  logic [31:0]     head_pc;
  logic            head_pt;
  logic [31:0]     head_tgt;
  logic            in_run;
  logic            do_pop;
  logic            do_push;
  logic            miss;

  // Head-of-queue view and the push/pop/mispredict decisions for this cycle.
  always_comb begin
    head_pc    = pc_q[rd_ptr];
    head_pt    = pt_q[rd_ptr];
    head_tgt   = tgt_q[rd_ptr];
    queue_full = (count == CW'(DEPTH));
    in_run     = (state == RUN);
    do_pop     = in_run && ex_valid && (count != '0);
    miss       = do_pop && ((head_pt != ex_taken) ||
                            (head_pt && ex_taken && (head_tgt != ex_target)));
    // A push coinciding with a mispredict belongs to the wrong path.
    do_push    = in_run && fetch_valid && !queue_full && !miss;
  end

  // Prediction storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_q[wr_ptr]  <= fetch_pc;
      pt_q[wr_ptr]  <= fetch_pred_taken;
      tgt_q[wr_ptr] <= fetch_pred_target;
    end
  end

  // Queue pointers and occupancy; a mispredict empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (miss) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered resolution results: training pulse and redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update         <= 1'b0;
      actual_taken   <= 1'b0;
      mispredict     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      update         <= do_pop;
      actual_taken   <= do_pop ? ex_taken : 1'b0;
      mispredict     <= miss;
      redirect_valid <= miss;
      if (miss) redirect_pc <= ex_taken ? ex_target : head_pc + 32'd4;
    end
  end

  // RUN/FLUSH sequencing; flush rises together with redirect_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      flush     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            state     <= FLUSH;
            flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            flush     <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag: EXE resolved a branch that was never recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          order_err <= 1'b0;
    else if (in_run && ex_valid && count == '0) order_err <= 1'b1;
  end

`ifdef BRU_PERF_CNT_EN
  // Event counters driven by the registered pulses, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (update)     perf_branches    <= perf_branches + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, random traffic
// against a queue-based reference model, and an async reset mid-flush.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        fv, fpt, ev, et;
  logic [31:0] fpc, ftgt, etgt;
  logic        queue_full, update, actual_taken, mispredict, redirect_valid, flush, order_err;
  logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fv), .fetch_pc(fpc), .fetch_pred_taken(fpt), .fetch_pred_target(ftgt),
    .ex_valid(ev), .ex_taken(et), .ex_target(etgt),
    .queue_full(queue_full), .update(update), .actual_taken(actual_taken),
    .mispredict(mispredict), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush),
`ifdef BRU_PERF_CNT_EN
    .order_err(order_err), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`else
    .order_err(order_err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  logic        m_upd, m_at, m_mp, m_fl, m_oe;
  logic [31:0] m_rpc, m_pb, m_pm;
  int          m_fl_left;

  function automatic void model_reset();
    m_q.delete();
    m_upd = 0; m_at = 0; m_mp = 0; m_fl = 0; m_oe = 0;
    m_rpc = 0; m_pb = 0; m_pm = 0; m_fl_left = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    ent_t h;
    logic miss, full;
    m_pb += {31'd0, m_upd};
    m_pm += {31'd0, m_mp};
    m_upd = 0;
    m_mp  = 0;
    m_at  = 0;
    if (m_fl) begin
      // While flush is high the unit ignores IF and EXE completely.
      if (m_fl_left > 0) m_fl_left--;
      else m_fl = 0;
      return;
    end
    full = (m_q.size() == DEPTH);
    miss = 0;
    if (ev && m_q.size() == 0) m_oe = 1;
    if (ev && m_q.size() != 0) begin
      h = m_q.pop_front();
      m_upd = 1;
      m_at  = et;
      miss  = (h.pt != et) || (h.pt && et && h.tgt != etgt);
      if (miss) begin
        m_mp  = 1;
        m_rpc = et ? etgt : h.pc + 32'd4;
        m_q.delete();
        m_fl = 1;
        m_fl_left = FC - 1;
      end
    end
    if (fv && !full && !miss) m_q.push_back('{pc: fpc, pt: fpt, tgt: ftgt});
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".queue_full"}, {31'd0, queue_full}, {31'd0, m_q.size() == DEPTH});
    chk({tag, ".update"}, {31'd0, update}, {31'd0, m_upd});
    if (m_upd) chk({tag, ".actual_taken"}, {31'd0, actual_taken}, {31'd0, m_at});
    chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, m_mp});
    chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, m_mp});
    chk({tag, ".redirect_pc"}, redirect_pc, m_rpc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_fl});
    chk({tag, ".order_err"}, {31'd0, order_err}, {31'd0, m_oe});
`ifdef BRU_PERF_CNT_EN
    chk({tag, ".perf_branches"}, perf_branches, m_pb);
    chk({tag, ".perf_mispredicts"}, perf_mispredicts, m_pm);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    fv = 0; fpc = 0; fpt = 0; ftgt = 0; ev = 0; et = 0; etgt = 0;
  endtask

  // One clock: model sees the same inputs as the DUT, outputs sampled #1 later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        ev;
    logic        et;
    logic [31:0] etgt;
    logic        qf, upd, at, mp, fl, oe;
    logic [31:0] rpc;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl[NV];

  task automatic sv(input int i, input logic f, input logic [31:0] pc, input logic pt,
                    input logic [31:0] ptgt, input logic e, input logic t, input logic [31:0] etg,
                    input logic qf, input logic upd, input logic at, input logic mp,
                    input logic fl, input logic oe, input logic [31:0] rpc);
    tbl[i] = '{fv: f, pc: pc, pt: pt, ptgt: ptgt, ev: e, et: t, etgt: etg,
               qf: qf, upd: upd, at: at, mp: mp, fl: fl, oe: oe, rpc: rpc};
  endtask

  initial begin
    ent_t h;
    idle_inputs();

    //     i  fv pc         pt ptgt       ev et etgt       qf upd at mp fl oe rpc
    sv( 0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0);
    sv( 1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0, 1, 1, 0, 0, 0, 32'h0);
    sv( 2, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0);
    sv( 3, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 1, 0, 1, 1, 0, 32'h104);
    sv( 4, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h104);
    sv( 5, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h104);
    sv( 6, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h104);
    sv( 7, 0, 32'h0,   0, 32'h0,   1, 1, 32'h300, 0, 1, 1, 1, 1, 0, 32'h300);
    sv( 8, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h300);
    sv( 9, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(10, 1, 32'h10,  0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(11, 1, 32'h20,  1, 32'h220, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(12, 1, 32'h30,  0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(13, 1, 32'h40,  1, 32'h440, 0, 0, 32'h0,   1, 0, 0, 0, 0, 0, 32'h300);
    sv(14, 1, 32'h50,  1, 32'h550, 0, 0, 32'h0,   1, 0, 0, 0, 0, 0, 32'h300);
    sv(15, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 1, 0, 0, 0, 0, 32'h300);
    sv(16, 1, 32'h60,  0, 32'h0,   1, 1, 32'h220, 0, 1, 1, 0, 0, 0, 32'h300);
    sv(17, 1, 32'h70,  1, 32'h770, 0, 0, 32'h0,   1, 0, 0, 0, 0, 0, 32'h300);
    sv(18, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 1, 0, 0, 0, 0, 32'h300);
    sv(19, 0, 32'h0,   0, 32'h0,   1, 1, 32'h440, 0, 1, 1, 0, 0, 0, 32'h300);
    sv(20, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 1, 0, 0, 0, 0, 32'h300);
    sv(21, 0, 32'h0,   0, 32'h0,   1, 1, 32'h770, 0, 1, 1, 0, 0, 0, 32'h300);
    sv(22, 1, 32'h80,  1, 32'h900, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(23, 1, 32'h84,  0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(24, 1, 32'h88,  0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h300);
    sv(25, 1, 32'h8c,  0, 32'h0,   1, 0, 32'h0,   0, 1, 0, 1, 1, 0, 32'h84);
    sv(26, 1, 32'h90,  0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h84);
    sv(27, 1, 32'h94,  0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h84);
    sv(28, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 0, 1, 32'h84);
    sv(29, 1, 32'h98,  0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 0, 1, 32'h84);
    sv(30, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 1, 0, 0, 0, 1, 32'h84);

    // Reset state.
    do_reset();
    chk("rst.queue_full", {31'd0, queue_full}, 32'd0);
    chk("rst.update", {31'd0, update}, 32'd0);
    chk("rst.mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    chk("rst.flush", {31'd0, flush}, 32'd0);
    chk("rst.order_err", {31'd0, order_err}, 32'd0);

    // Directed table: each row is one clock of inputs and the outputs after it.
    for (int i = 0; i < NV; i++) begin
      fv = tbl[i].fv; fpc = tbl[i].pc; fpt = tbl[i].pt; ftgt = tbl[i].ptgt;
      ev = tbl[i].ev; et = tbl[i].et; etgt = tbl[i].etgt;
      cycle();
      chk($sformatf("v%0d.queue_full", i), {31'd0, queue_full}, {31'd0, tbl[i].qf});
      chk($sformatf("v%0d.update", i), {31'd0, update}, {31'd0, tbl[i].upd});
      if (tbl[i].upd)
        chk($sformatf("v%0d.actual_taken", i), {31'd0, actual_taken}, {31'd0, tbl[i].at});
      chk($sformatf("v%0d.mispredict", i), {31'd0, mispredict}, {31'd0, tbl[i].mp});
      chk($sformatf("v%0d.redirect_valid", i), {31'd0, redirect_valid}, {31'd0, tbl[i].mp});
      chk($sformatf("v%0d.redirect_pc", i), redirect_pc, tbl[i].rpc);
      chk($sformatf("v%0d.flush", i), {31'd0, flush}, {31'd0, tbl[i].fl});
      chk($sformatf("v%0d.order_err", i), {31'd0, order_err}, {31'd0, tbl[i].oe});
`ifdef BRU_PERF_CNT_EN
      chk($sformatf("v%0d.perf_branches", i), perf_branches, m_pb);
      chk($sformatf("v%0d.perf_mispredicts", i), perf_mispredicts, m_pm);
`endif
    end
    idle_inputs();
    cycle();
    chk_model("v_tail");

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      fv   = ($urandom_range(0, 1) == 1);
      fpc  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      fpt  = ($urandom_range(0, 1) == 1);
      ftgt = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
      ev   = ($urandom_range(0, 2) == 0);
      if (m_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        h = m_q[0];
        et = h.pt;
        etgt = h.tgt;
      end else begin
        et   = ($urandom_range(0, 1) == 1);
        etgt = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
      end
      cycle();
      chk_model($sformatf("r%0d", n));
    end

    // Asynchronous reset in the middle of a flush.
    do_reset();
    ev = 1; et = 0;
    cycle();
    chk_model("ar0");
    idle_inputs();
    fv = 1; fpc = 32'h400; fpt = 1; ftgt = 32'h500;
    cycle();
    chk_model("ar1");
    idle_inputs();
    ev = 1; et = 0;
    cycle();
    chk_model("ar2");
    idle_inputs();
    #2;
    reset_n = 0;
    #1;
    chk("ar.flush", {31'd0, flush}, 32'd0);
    chk("ar.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("ar.mispredict", {31'd0, mispredict}, 32'd0);
    chk("ar.update", {31'd0, update}, 32'd0);
    chk("ar.order_err", {31'd0, order_err}, 32'd0);
    chk("ar.redirect_pc", redirect_pc, 32'd0);
`ifdef BRU_PERF_CNT_EN
    chk("ar.perf_branches", perf_branches, 32'd0);
    chk("ar.perf_mispredicts", perf_mispredicts, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
    cycle();
    chk_model("ar3");

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
